bar_move_scheduler: RTL and testbench

BAR_MOVE_SCHEDULER -- requirements
Module: bar_move_scheduler

---
 rtl/bar_move_scheduler_if.sv | 10 +
 rtl/bar_move_scheduler.sv | 85 ++++++++
 tb/tb_bar_move_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bar_move_scheduler_if.sv
// bar_move_scheduler_if: move-request handshake between a requester and the bar scheduler
interface bar_move_scheduler_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_bar;
    logic       req_incDec;
    logic [8:0] req_step;
    modport master (output req_valid, req_bar, req_incDec, req_step, input req_ready);
    modport slave  (input req_valid, req_bar, req_incDec, req_step, output req_ready);
endinterface

// File: rtl/bar_move_scheduler.sv
// bar_move_scheduler: queues one move per bar and commits it, paced and aligned to blanking, round-robin
module bar_move_scheduler #(
    parameter int Y_INIT      = 195,
    parameter int BAR_H       = 90,
    parameter int Y_MIN       = 6,
    parameter int Y_MAX       = 479,
    parameter int PACE_CYCLES = 1048575
) (
    input  logic                 clk_in,
    input  logic                 i_rst,
    bar_move_scheduler_if.slave  req,
    input  logic                 o_active,
    output logic [8:0]           y_left,
    output logic [8:0]           y_right,
    output logic                 busy,
    output logic                 grant_bar
);
    typedef enum logic [1:0] {IDLE, PACE, WAIT_BLANK, COMMIT} state_t;
    localparam logic [10:0] Y_LO  = 11'(Y_MIN);
    localparam logic [10:0] Y_HI  = 11'(Y_MAX);
    localparam logic [10:0] H     = 11'(BAR_H);
    localparam logic [10:0] Y_SAT = 11'(Y_MAX - BAR_H + 1);
    localparam logic [19:0] PACE_LAST = 20'(PACE_CYCLES - 1);
    state_t      state;
    logic [1:0]  slot_valid;
    logic [1:0]  slot_inc;
    logic [8:0]  slot_step [2];
    logic        last_grant;
    logic [19:0] pace_cnt;
    logic [10:0] y_cur;
    logic [10:0] step;
    logic [8:0]  y_new;
    logic        accept;
    assign req.req_ready = !slot_valid[req.req_bar];
    assign accept = req.req_valid && req.req_ready;
    // 11-bit math keeps y+step+BAR_H clear of wrap-around before clamping
    always_comb begin
        y_cur = {2'b0, grant_bar ? y_right : y_left};
        step  = {2'b0, slot_step[grant_bar]};
        y_new = slot_inc[grant_bar]
              ? ((y_cur + step + H - 11'd1 <= Y_HI) ? 9'(y_cur + step) : 9'(Y_SAT))
              : ((y_cur >= Y_LO + step) ? 9'(y_cur - step) : 9'(Y_LO));
    end
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            y_left     <= 9'(Y_INIT);
            y_right    <= 9'(Y_INIT);
            slot_valid <= 2'b00;
            slot_inc   <= 2'b00;
            slot_step  <= '{default: '0};
            last_grant <= 1'b1;
            grant_bar  <= 1'b0;
            busy       <= 1'b0;
            pace_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (|slot_valid) begin
                    grant_bar <= (&slot_valid) ? !last_grant : slot_valid[1];
                    pace_cnt  <= '0;
                    busy      <= 1'b1;
                    state     <= PACE;
                end
                PACE: if (pace_cnt == PACE_LAST) state <= WAIT_BLANK;
                      else pace_cnt <= pace_cnt + 20'd1;
                WAIT_BLANK: if (!o_active) state <= COMMIT;
                COMMIT: begin
                    if (grant_bar) y_right <= y_new;
                    else y_left <= y_new;
                    slot_valid[grant_bar] <= 1'b0;
                    last_grant <= grant_bar;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // the granted slot cannot be accepted during COMMIT, so this never races the clear above
            if (accept) begin
                slot_valid[req.req_bar] <= 1'b1;
                slot_inc[req.req_bar]   <= req.req_incDec;
                slot_step[req.req_bar]  <= req.req_step;
            end
        end
    end
endmodule

// File: tb/tb_bar_move_scheduler.sv
// tb_bar_move_scheduler: directed stimulus, timestamp-based reference model checked every cycle
module tb_bar_move_scheduler;
    localparam int PACE = 4, YI = 195, BH = 90, YMIN = 6, YMAX = 479;
    logic clk_in = 1'b0, i_rst = 1'b0, o_active = 1'b0;
    logic [8:0] y_left, y_right;
    logic busy, grant_bar;
    bar_move_scheduler_if bus();
    bar_move_scheduler #(.PACE_CYCLES(PACE)) dut (
        .clk_in(clk_in), .i_rst(i_rst), .req(bus.slave), .o_active(o_active),
        .y_left(y_left), .y_right(y_right), .busy(busy), .grant_bar(grant_bar)
    );
    always #5 clk_in = ~clk_in;
    int compared = 0, mismatched = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Model: a service granted at edge k commits one edge after the first edge beyond k+PACE that sees o_active low
    int n = 0, m_k = 0, m_commit_at = -1;
    int m_y[2] = '{YI, YI};
    int m_step[2] = '{0, 0};
    bit m_valid[2] = '{0, 0};
    bit m_inc[2] = '{0, 0};
    bit m_busy = 0, m_grant = 0, m_last = 1;
    always @(posedge clk_in) begin : model
        bit acc;
        int y, s;
        n++;
        if (!i_rst) begin
            m_y = '{YI, YI}; m_valid = '{0, 0}; m_busy = 0; m_grant = 0; m_last = 1; m_commit_at = -1;
        end else begin
            acc = bus.req_valid && !m_valid[bus.req_bar];
            if (m_busy) begin
                if (n == m_commit_at) begin
                    y = m_y[m_grant];
                    s = m_step[m_grant];
                    if (m_inc[m_grant]) y = (y + s > YMAX - BH + 1) ? YMAX - BH + 1 : y + s;
                    else y = (y - s < YMIN) ? YMIN : y - s;
                    m_y[m_grant] = y;
                    m_valid[m_grant] = 0;
                    m_last = m_grant;
                    m_busy = 0;
                    m_commit_at = -1;
                end else if (m_commit_at < 0 && n > m_k + PACE && !o_active) m_commit_at = n + 1;
            end else if (m_valid[0] || m_valid[1]) begin
                m_grant = (m_valid[0] && m_valid[1]) ? !m_last : m_valid[1];
                m_k = n;
                m_busy = 1;
            end
            if (acc) begin
                m_valid[bus.req_bar] = 1;
                m_inc[bus.req_bar] = bus.req_incDec;
                m_step[bus.req_bar] = int'(bus.req_step);
            end
        end
    end
    always @(posedge clk_in) begin : compare
        #2;
        chk("y_left", 32'(y_left), 32'(m_y[0]));
        chk("y_right", 32'(y_right), 32'(m_y[1]));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("req_ready", 32'(bus.req_ready), 32'(!m_valid[bus.req_bar]));
        if (m_busy) chk("grant_bar", 32'(grant_bar), 32'(m_grant));
    end
    task automatic send(input bit b, input bit inc, input int s, output int waited);
        logic r;
        @(negedge clk_in);
        bus.req_valid = 1'b1; bus.req_bar = b; bus.req_incDec = inc; bus.req_step = 9'(s);
        waited = 0;
        while (1) begin
            #1 r = bus.req_ready;
            @(posedge clk_in);
            if (r) break;
            waited++;
            if (waited > 300) begin
                chk("accept_timeout", 32'(waited), 32'd0);
                break;
            end
            @(negedge clk_in);
        end
        #1 bus.req_valid = 1'b0;
    endtask
    task automatic wait_idle();
        int i = 0;
        repeat (2) @(posedge clk_in);
        #1;
        while (busy && i < 400) begin
            @(posedge clk_in);
            #1;
            i++;
        end
        if (i >= 400) chk("idle_timeout", 32'(busy), 32'd0);
    endtask
    initial begin
        int w, w2, n1;
        bus.req_valid = 1'b0; bus.req_bar = 1'b0; bus.req_incDec = 1'b0; bus.req_step = '0;
        repeat (2) @(negedge clk_in);
        i_rst = 1'b1;
        @(posedge clk_in); #1;
        chk("rst_y_left", 32'(y_left), 32'd195);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        send(0, 1, 10, w);
        repeat (6) @(posedge clk_in);
        #1 chk("single_pre_commit", 32'(y_left), 32'd195);
        chk("single_busy", 32'(busy), 32'd1);
        @(posedge clk_in);
        #1 chk("single_commit", 32'(y_left), 32'd205);
        chk("single_y_right", 32'(y_right), 32'd195);
        send(0, 1, 250, w); wait_idle();
        chk("sat_down", 32'(y_left), 32'd390);
        send(0, 0, 400, w); wait_idle();
        chk("sat_up", 32'(y_left), 32'd6);
        @(negedge clk_in) i_rst = 1'b0;
        @(negedge clk_in) i_rst = 1'b1;
        send(0, 1, 20, w);
        send(1, 0, 30, w);
        chk("rr_first_grant", 32'(grant_bar), 32'd0);
        wait_idle();
        n1 = n;
        chk("rr_left", 32'(y_left), 32'd215);
        chk("rr_right_untouched", 32'(y_right), 32'd195);
        @(posedge clk_in);
        #1 chk("rr_second_grant", 32'(grant_bar), 32'd1);
        wait_idle();
        chk("rr_right", 32'(y_right), 32'd165);
        chk("rr_gap", 32'(n - n1), 32'd7);
        @(negedge clk_in) o_active = 1'b1;
        send(0, 1, 5, w);
        repeat (106) @(posedge clk_in);
        #1 chk("blank_busy", 32'(busy), 32'd1);
        chk("blank_hold", 32'(y_left), 32'd215);
        @(negedge clk_in) o_active = 1'b0;
        @(posedge clk_in);
        #1 chk("blank_in_commit", 32'(y_left), 32'd215);
        @(posedge clk_in);
        #1 chk("blank_commit", 32'(y_left), 32'd220);
        send(0, 1, 3, w);
        send(0, 0, 50, w2);
        chk("held_wait", 32'(w2), 32'd7);
        chk("held_after_commit", 32'(y_left), 32'd223);
        wait_idle();
        chk("held_second", 32'(y_left), 32'd173);
        send(1, 0, 0, w); wait_idle();
        chk("step_zero", 32'(y_right), 32'd165);
        send(0, 1, 40, w);
        send(1, 1, 300, w);
        chk("other_bar_wait", 32'(w), 32'd0);
        wait_idle(); wait_idle();
        chk("other_left", 32'(y_left), 32'd213);
        chk("other_right", 32'(y_right), 32'd390);
        @(negedge clk_in) o_active = 1'b1;
        send(1, 0, 100, w);
        repeat (7) @(posedge clk_in);
        @(negedge clk_in) i_rst = 1'b0;
        #1 chk("midrst_y_left", 32'(y_left), 32'd195);
        chk("midrst_y_right", 32'(y_right), 32'd195);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk_in) i_rst = 1'b1;
        o_active = 1'b0;
        repeat (10) @(posedge clk_in);
        #1 chk("midrst_no_commit", 32'(y_right), 32'd195);
        repeat (2) @(posedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
